// File: rtl/inst_fetch_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_bus_pkg
//  Description : Shared pipe types and constants for the instruction fetch bus
//                master (state encoding, invalid-instruction word, counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_bus_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

    // Same encoding the fetch stage uses for "no valid instruction".
    localparam logic [31:0] INSTRUCTION_INVALID = 32'hFFFF_FFFF;

    function automatic int timeout_width(input int cycles);
        return ($clog2(cycles) > 0) ? $clog2(cycles) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_bus_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_bus_if
//  Description : Single-word read instruction bus between the fetch bus master
//                and the instruction memory slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_bus_if;
    logic [31:0] busAddress;
    logic        busRequest;
    logic        busAck;
    logic        busError;
    logic [31:0] busReadData;

    modport master (
        output busAddress,
        output busRequest,
        input  busAck,
        input  busError,
        input  busReadData
    );

    modport slave (
        input  busAddress,
        input  busRequest,
        output busAck,
        output busError,
        output busReadData
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_timeout
//  Description : Bus wait-cycle counter; flags expiry on the last allowed WAIT
//                cycle so the master can abandon the transaction.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_timeout
    import inst_fetch_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    output logic expired
);

    localparam int              CW      = timeout_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]   c_limit = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            r_count <= '0;
        end else if (active && (r_count != c_limit)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = active && (r_count == c_limit);

endmodule
`default_nettype wire

// File: rtl/inst_fetch_bus.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_bus
//  Description : Instruction-side bus master with one address-tagged result
//                register. Optional bus timeout enabled by INST_FETCH_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_bus
    import inst_fetch_bus_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES    = 16,
    parameter logic [31:0] RESET_INSTRUCTION = INSTRUCTION_INVALID
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             fetchAddress,
    input  logic                    fetchEnable,
    input  logic                    fetchFlush,
    output logic                    fetchBusy,
    output logic [31:0]             currentInstruction,
    output logic                    fetchError,
    inst_fetch_bus_if.master        bus
);

    fetch_state_e r_state;
    logic         r_result_valid;
    logic [31:0]  r_result_tag;
    logic [31:0]  r_req_tag;
    logic [31:0]  r_bus_address;
    logic         r_bus_request;
    logic [31:0]  r_current_instruction;
    logic         r_fetch_error;
    logic         r_discard_pending;

    logic w_hit;
    logic w_issue;
    logic w_in_wait;
    logic w_timeout;
    logic w_complete;
    logic w_drop;

    assign w_hit      = r_result_valid && (r_result_tag == fetchAddress);
    assign fetchBusy  = fetchEnable && !w_hit;
    assign w_in_wait  = (r_state == WAIT);
    assign w_issue    = (r_state == IDLE) && fetchEnable && !w_hit && !fetchFlush;
    assign w_complete = w_in_wait && (bus.busAck || bus.busError || w_timeout);
    // A flush arriving with the response discards it just like an earlier flush.
    assign w_drop     = r_discard_pending || fetchFlush;

`ifdef INST_FETCH_TIMEOUT_EN
    inst_fetch_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .start   (w_issue),
        .active  (w_in_wait),
        .expired (w_timeout)
    );
`else
    logic [31:0] w_unused_timeout_cycles;
    assign w_unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state               <= IDLE;
            r_bus_request         <= 1'b0;
            r_bus_address         <= '0;
            r_current_instruction <= RESET_INSTRUCTION;
            r_fetch_error         <= 1'b0;
            r_result_valid        <= 1'b0;
            r_result_tag          <= '0;
            r_req_tag             <= '0;
            r_discard_pending     <= 1'b0;
        end else begin
            if (fetchFlush) begin
                r_result_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_bus_address <= {fetchAddress[31:2], 2'b00};
                        r_req_tag     <= fetchAddress;
                        r_bus_request <= 1'b1;
                        r_state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_complete) begin
                        if (!w_drop) begin
                            r_result_tag   <= r_req_tag;
                            r_result_valid <= 1'b1;
                            // Priority: error, then ack, then timeout.
                            if (bus.busError) begin
                                r_current_instruction <= RESET_INSTRUCTION;
                                r_fetch_error         <= 1'b1;
                            end else if (bus.busAck) begin
                                r_current_instruction <= bus.busReadData;
                                r_fetch_error         <= 1'b0;
                            end else begin
                                r_current_instruction <= RESET_INSTRUCTION;
                                r_fetch_error         <= 1'b1;
                            end
                        end
                        r_bus_request     <= 1'b0;
                        r_discard_pending <= 1'b0;
                        r_state           <= IDLE;
                    end else if (fetchFlush) begin
                        r_discard_pending <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busAddress     = r_bus_address;
    assign bus.busRequest     = r_bus_request;
    assign currentInstruction = r_current_instruction;
    assign fetchError         = r_fetch_error;

endmodule
`default_nettype wire
